// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter data sequencer.
// Holds the sequencer state encoding and the LFU minterm selections used by software.
package blit_pkg;

  localparam int LFUC_W = 4;

  // Minterm index into LFUC is {srcd bit, dstd bit}
  localparam logic [LFUC_W-1:0] LFU_COPY = 4'b1100;
  localparam logic [LFUC_W-1:0] LFU_XOR  = 4'b0110;

  typedef enum logic [2:0] {
    IDLE,
    SRD,
    DRD,
    CALC,
    WR,
    DONE
  } blit_state_e;

  // First state of each byte: source read, else destination read, else straight to compute
  function automatic blit_state_e first_phase(input logic src_en, input logic dst_en);
    if (src_en) begin
      return SRD;
    end else if (dst_en) begin
      return DRD;
    end else begin
      return CALC;
    end
  endfunction

endpackage

// File: rtl/blit_mem_port.sv
// Request/acknowledge holding register for the blitter memory port.
// Fields are loaded only on issue, so they stay stable until the transaction is acknowledged.
module blit_mem_port #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic          CLK,
  input  logic          RESETL,
  input  logic          issue,
  input  logic          issue_wr,
  input  logic [AW-1:0] issue_addr,
  input  logic          wdata_ld,
  input  logic [DW-1:0] wdata_in,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  // A new issue wins over completion so req can stay high across back-to-back phases
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      mem_req  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
    end else if (issue) begin
      mem_req  <= 1'b1;
      mem_wr   <= issue_wr;
      mem_addr <= issue_addr;
    end else if (mem_req && mem_ack) begin
      mem_req <= 1'b0;
      mem_wr  <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      mem_wdata <= '0;
    end else if (wdata_ld) begin
      mem_wdata <= wdata_in;
    end
  end

endmodule

// File: rtl/blit_data_seq.sv
// Blitter data sequencer: fetches source/destination bytes, feeds the LFU slices and writes results back.
// Optional compare-inhibit feature enabled by defining BLIT_CMP_INHIBIT_EN.
module blit_data_seq
  import blit_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int CW = 9
) (
  input  logic              CLK,
  input  logic              RESETL,
  input  logic              start,
  input  logic [AW-1:0]     src_addr,
  input  logic [AW-1:0]     dst_addr,
  input  logic [CW-1:0]     count,
  input  logic [LFUC_W-1:0] lfuc,
  input  logic              src_en,
  input  logic              dst_en,
  input  logic [DW-1:0]     pattern,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata,
  output logic [DW-1:0]     srcd,
  output logic [DW-1:0]     dstd,
  output logic [LFUC_W-1:0] lfuc_q,
  input  logic [DW-1:0]     lfu_dout,
`ifdef BLIT_CMP_INHIBIT_EN
  input  logic              cmp_en,
  input  logic [DW-1:0]     cmp_val,
  output logic              coll,
`endif
  output logic              busy,
  output logic              done
);

  blit_state_e   state;
  blit_state_e   next_state;
  logic [AW-1:0] saddr;
  logic [AW-1:0] daddr;
  logic [CW-1:0] cnt;
  logic [AW-1:0] saddr_nxt;
  logic [AW-1:0] daddr_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          src_en_q;
  logic          dst_en_q;
  logic          ack_v;
  logic          accept;
  logic          cmp_hit;
  logic          issue;
  logic          issue_wr;
  logic [AW-1:0] issue_addr;

  assign ack_v  = mem_ack && mem_req;
  assign accept = (state == IDLE) && start;

`ifdef BLIT_CMP_INHIBIT_EN
  logic          cmp_en_q;
  logic [DW-1:0] cmp_val_q;

  assign cmp_hit = cmp_en_q && (srcd == cmp_val_q);

  // Compare settings are frozen per run; coll records any inhibited write since the last start
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      cmp_en_q  <= 1'b0;
      cmp_val_q <= '0;
      coll      <= 1'b0;
    end else if (accept) begin
      cmp_en_q  <= cmp_en;
      cmp_val_q <= cmp_val;
      coll      <= 1'b0;
    end else if (state == CALC && cmp_hit) begin
      coll <= 1'b1;
    end
  end
`else
  assign cmp_hit = 1'b0;
`endif

  // Next state plus next address/count; a memory phase is issued on entry so requests start without a bubble
  always_comb begin
    next_state = state;
    saddr_nxt  = saddr;
    daddr_nxt  = daddr;
    cnt_nxt    = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          saddr_nxt = src_addr;
          daddr_nxt = dst_addr;
          cnt_nxt   = count;
          if (count == '0) begin
            next_state = DONE;
          end else begin
            next_state = first_phase(src_en, dst_en);
          end
        end
      end
      SRD: begin
        if (ack_v) begin
          saddr_nxt  = saddr + AW'(1);
          next_state = dst_en_q ? DRD : CALC;
        end
      end
      DRD: begin
        if (ack_v) begin
          next_state = CALC;
        end
      end
      CALC: begin
        if (cmp_hit) begin
          daddr_nxt = daddr + AW'(1);
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end
          next_state = (cnt <= CW'(1)) ? DONE : first_phase(src_en_q, dst_en_q);
        end else begin
          next_state = WR;
        end
      end
      WR: begin
        if (ack_v) begin
          daddr_nxt = daddr + AW'(1);
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end
          next_state = (cnt <= CW'(1)) ? DONE : first_phase(src_en_q, dst_en_q);
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    issue      = (next_state != state) &&
                 (next_state == SRD || next_state == DRD || next_state == WR);
    issue_wr   = (next_state == WR);
    issue_addr = (next_state == SRD) ? saddr_nxt : daddr_nxt;
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state    <= IDLE;
      saddr    <= '0;
      daddr    <= '0;
      cnt      <= '0;
      src_en_q <= 1'b0;
      dst_en_q <= 1'b0;
      lfuc_q   <= '0;
      srcd     <= '0;
      dstd     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= next_state;
      saddr <= saddr_nxt;
      daddr <= daddr_nxt;
      cnt   <= cnt_nxt;
      busy  <= (next_state != IDLE) && (next_state != DONE);
      done  <= (next_state == DONE);
      if (accept) begin
        src_en_q <= src_en;
        dst_en_q <= dst_en;
        lfuc_q   <= lfuc;
        dstd     <= '0;
        if (!src_en) begin
          srcd <= pattern;
        end
      end
      if (state == SRD && ack_v) begin
        srcd <= mem_rdata;
      end
      if (state == DRD && ack_v) begin
        dstd <= mem_rdata;
      end
    end
  end

  blit_mem_port #(
    .DW(DW),
    .AW(AW)
  ) u_mem_port (
    .CLK       (CLK),
    .RESETL    (RESETL),
    .issue     (issue),
    .issue_wr  (issue_wr),
    .issue_addr(issue_addr),
    .wdata_ld  (state == CALC),
    .wdata_in  (lfu_dout),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_blit_data_seq.sv
// Directed testbench for blit_data_seq with a behavioural LFU and a byte memory responder.
// Define BLIT_CMP_INHIBIT_EN to also exercise the compare-inhibit feature.
module tb_blit_data_seq;
  import blit_pkg::*;

  logic        CLK = 1'b0;
  logic        RESETL = 1'b0;
  logic        start = 1'b0;
  logic [19:0] src_addr = '0;
  logic [19:0] dst_addr = '0;
  logic [8:0]  count = '0;
  logic [3:0]  lfuc = '0;
  logic        src_en = 1'b0;
  logic        dst_en = 1'b0;
  logic [7:0]  pattern = '0;
  logic        mem_req, mem_wr;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  srcd, dstd, lfu_dout;
  logic [3:0]  lfuc_q;
  logic        busy, done;
`ifdef BLIT_CMP_INHIBIT_EN
  logic        cmp_en = 1'b0;
  logic [7:0]  cmp_val = '0;
  logic        coll;
`endif

  int total = 0;
  int bad = 0;
  int ack_delay = 0;
  bit chk_stab = 1'b0;
  int wait_cnt = 0;
  logic [19:0] cap_addr;
  logic        cap_wr;
  logic [7:0]  cap_wdata;
  logic [7:0]  mem [int];
  logic [19:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [19:0] rd_addr_q[$];

  always #5 CLK = ~CLK;

  blit_data_seq dut (
    .CLK      (CLK),
    .RESETL   (RESETL),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .lfuc     (lfuc),
    .src_en   (src_en),
    .dst_en   (dst_en),
    .pattern  (pattern),
    .mem_req  (mem_req),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .srcd     (srcd),
    .dstd     (dstd),
    .lfuc_q   (lfuc_q),
    .lfu_dout (lfu_dout),
`ifdef BLIT_CMP_INHIBIT_EN
    .cmp_en   (cmp_en),
    .cmp_val  (cmp_val),
    .coll     (coll),
`endif
    .busy     (busy),
    .done     (done)
  );

  // Behavioural LFU slices: each bit picks the minterm {src, dst}
  always_comb begin
    lfu_dout = '0;
    for (int i = 0; i < 8; i++) lfu_dout[i] = lfuc_q[{srcd[i], dstd[i]}];
  end

  function automatic logic [7:0] rd_mem(input logic [19:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 8'h00;
  endfunction

  // Memory responder: acks after ack_delay wait cycles and checks request fields hold while waiting
  always @(negedge CLK) begin
    if (!RESETL || !mem_req) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else begin
      if (mem_ack) wait_cnt = 0;
      if (wait_cnt == 0) begin
        cap_addr = mem_addr;
        cap_wr = mem_wr;
        cap_wdata = mem_wdata;
      end else if (chk_stab) begin
        total++;
        if (mem_addr !== cap_addr || mem_wr !== cap_wr || (cap_wr && mem_wdata !== cap_wdata)) begin
          bad++;
          $display("[TB] FAIL hold_stable: got addr=%h wr=%b wdata=%h expected addr=%h wr=%b wdata=%h",
                   mem_addr, mem_wr, mem_wdata, cap_addr, cap_wr, cap_wdata);
        end
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem_wr ? 8'h00 : rd_mem(mem_addr);
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Transaction log of every acknowledged request
  always @(posedge CLK) begin
    if (RESETL && mem_req && mem_ack) begin
      if (mem_wr) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        mem[int'(mem_addr)] = mem_wdata;
      end else begin
        rd_addr_q.push_back(mem_addr);
      end
    end
  end

  task automatic set_cmd(input logic [19:0] s, input logic [19:0] d, input logic [8:0] c,
                         input logic [3:0] f, input logic se, input logic de, input logic [7:0] p);
    src_addr = s;
    dst_addr = d;
    count = c;
    lfuc = f;
    src_en = se;
    dst_en = de;
    pattern = p;
  endtask

  // Pulse start and count negedges until done; optionally disturb inputs and re-pulse start mid-run
  task automatic run_blit(input bit disturb, output int lat, output logic busy1);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    lat = -1;
    busy1 = 1'bx;
    @(negedge CLK);
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge CLK);
      start = 1'b0;
      if (n == 1) busy1 = busy;
      if (disturb && n == 2) set_cmd(20'h55555, 20'h66666, 9'd7, 4'h0, 1'b0, 1'b0, 8'h77);
      if (disturb && n == 5) start = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req: got %b expected 0", mem_req); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr: got %b expected 0", mem_wr); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
    total++; if (mem_addr !== 20'h0) begin bad++; $display("[TB] FAIL rst_addr: got %h expected 0", mem_addr); end
    total++; if (mem_wdata !== 8'h0) begin bad++; $display("[TB] FAIL rst_wdata: got %h expected 0", mem_wdata); end
    total++; if (srcd !== 8'h0 || dstd !== 8'h0) begin bad++; $display("[TB] FAIL rst_data: got %h/%h expected 0/0", srcd, dstd); end
    total++; if (lfuc_q !== 4'h0) begin bad++; $display("[TB] FAIL rst_lfuc: got %h expected 0", lfuc_q); end
`ifdef BLIT_CMP_INHIBIT_EN
    total++; if (coll !== 1'b0) begin bad++; $display("[TB] FAIL rst_coll: got %b expected 0", coll); end
`endif
  endtask

  task automatic test_copy();
    int lat;
    logic b1;
    logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33;
    ack_delay = 0;
    set_cmd(20'h00100, 20'h00200, 9'd3, LFU_COPY, 1'b1, 1'b1, 8'h00);
    run_blit(1'b1, lat, b1);
    total++; if (lat !== 13) begin bad++; $display("[TB] FAIL copy_latency: got %0d expected 13", lat); end
    total++; if (b1 !== 1'b1) begin bad++; $display("[TB] FAIL copy_busy: got %b expected 1", b1); end
    total++; if (wr_addr_q.size() !== 3) begin bad++; $display("[TB] FAIL copy_nwr: got %0d expected 3", wr_addr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_addr_q[i] !== 20'h00200 + 20'(i) || wr_data_q[i] !== exp_d[i]) begin
        bad++; $display("[TB] FAIL copy_wr%0d: got %h:%h expected %h:%h", i, wr_addr_q[i], wr_data_q[i], 20'h00200 + 20'(i), exp_d[i]);
      end
    end
    @(negedge CLK);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL copy_end: got done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_pattern_xor();
    int lat;
    logic b1;
    mem[32'h300] = 8'hFF;
    ack_delay = 0;
    set_cmd(20'h00100, 20'h00300, 9'd1, LFU_XOR, 1'b0, 1'b1, 8'hA5);
    run_blit(1'b0, lat, b1);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL xor_latency: got %0d expected 4", lat); end
    total++; if (rd_addr_q.size() !== 1) begin bad++; $display("[TB] FAIL xor_nrd: got %0d expected 1", rd_addr_q.size()); end
    else begin
      total++; if (rd_addr_q[0] !== 20'h00300) begin bad++; $display("[TB] FAIL xor_rdaddr: got %h expected 00300", rd_addr_q[0]); end
    end
    total++; if (wr_addr_q.size() !== 1) begin bad++; $display("[TB] FAIL xor_nwr: got %0d expected 1", wr_addr_q.size()); end
    else begin
      total++; if (wr_addr_q[0] !== 20'h00300 || wr_data_q[0] !== 8'h5A) begin
        bad++; $display("[TB] FAIL xor_wr: got %h:%h expected 00300:5a", wr_addr_q[0], wr_data_q[0]);
      end
    end
  endtask

  task automatic test_wait_states();
    int lat;
    logic b1;
    logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
    ack_delay = 3;
    chk_stab = 1'b1;
    set_cmd(20'h00100, 20'h00200, 9'd3, LFU_COPY, 1'b1, 1'b1, 8'h00);
    run_blit(1'b0, lat, b1);
    chk_stab = 1'b0;
    ack_delay = 0;
    total++; if (lat !== 40) begin bad++; $display("[TB] FAIL wait_latency: got %0d expected 40", lat); end
    total++; if (wr_addr_q.size() !== 3) begin bad++; $display("[TB] FAIL wait_nwr: got %0d expected 3", wr_addr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_addr_q[i] !== 20'h00200 + 20'(i) || wr_data_q[i] !== exp_d[i]) begin
        bad++; $display("[TB] FAIL wait_wr%0d: got %h:%h expected %h:%h", i, wr_addr_q[i], wr_data_q[i], 20'h00200 + 20'(i), exp_d[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic b1;
    ack_delay = 0;
    set_cmd(20'h00100, 20'hFFFFF, 9'd2, LFU_COPY, 1'b1, 1'b1, 8'h00);
    run_blit(1'b0, lat, b1);
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL wrap_latency: got %0d expected 9", lat); end
    total++; if (wr_addr_q.size() !== 2) begin bad++; $display("[TB] FAIL wrap_nwr: got %0d expected 2", wr_addr_q.size()); end
    else begin
      total++; if (wr_addr_q[0] !== 20'hFFFFF || wr_data_q[0] !== 8'h11) begin
        bad++; $display("[TB] FAIL wrap_wr0: got %h:%h expected fffff:11", wr_addr_q[0], wr_data_q[0]);
      end
      total++; if (wr_addr_q[1] !== 20'h00000 || wr_data_q[1] !== 8'h22) begin
        bad++; $display("[TB] FAIL wrap_wr1: got %h:%h expected 00000:22", wr_addr_q[1], wr_data_q[1]);
      end
    end
  endtask

  task automatic test_count_zero();
    int lat;
    logic b1;
    set_cmd(20'h00100, 20'h00200, 9'd0, LFU_COPY, 1'b1, 1'b1, 8'h00);
    run_blit(1'b0, lat, b1);
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL zero_latency: got %0d expected 1", lat); end
    total++; if (wr_addr_q.size() + rd_addr_q.size() !== 0) begin
      bad++; $display("[TB] FAIL zero_traffic: got %0d expected 0", wr_addr_q.size() + rd_addr_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic b1;
    bit found;
    logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
    ack_delay = 0;
    found = 1'b0;
    set_cmd(20'h00100, 20'h00200, 9'd3, LFU_COPY, 1'b1, 1'b1, 8'h00);
    @(negedge CLK);
    start = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      start = 1'b0;
      if (mem_req && mem_wr) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("[TB] FAIL rstwr_reach: got %b expected 1", found); end
    RESETL = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rstwr_req: got %b expected 0", mem_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstwr_busy: got %b expected 0", busy); end
    total++; if (mem_addr !== 20'h0) begin bad++; $display("[TB] FAIL rstwr_addr: got %h expected 0", mem_addr); end
    repeat (2) @(negedge CLK);
    RESETL = 1'b1;
    run_blit(1'b0, lat, b1);
    total++; if (lat !== 13) begin bad++; $display("[TB] FAIL rstwr_latency: got %0d expected 13", lat); end
    total++; if (wr_addr_q.size() !== 3) begin bad++; $display("[TB] FAIL rstwr_nwr: got %0d expected 3", wr_addr_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_addr_q[i] !== 20'h00200 + 20'(i) || wr_data_q[i] !== exp_d[i]) begin
        bad++; $display("[TB] FAIL rstwr_wr%0d: got %h:%h expected %h:%h", i, wr_addr_q[i], wr_data_q[i], 20'h00200 + 20'(i), exp_d[i]);
      end
    end
  endtask

`ifdef BLIT_CMP_INHIBIT_EN
  task automatic test_cmp_inhibit();
    int lat;
    logic b1;
    ack_delay = 0;
    cmp_en = 1'b1;
    cmp_val = 8'h22;
    set_cmd(20'h00100, 20'h00200, 9'd3, LFU_COPY, 1'b1, 1'b1, 8'h00);
    run_blit(1'b0, lat, b1);
    cmp_en = 1'b0;
    total++; if (lat !== 12) begin bad++; $display("[TB] FAIL cmp_latency: got %0d expected 12", lat); end
    total++; if (coll !== 1'b1) begin bad++; $display("[TB] FAIL cmp_coll: got %b expected 1", coll); end
    total++; if (wr_addr_q.size() !== 2) begin bad++; $display("[TB] FAIL cmp_nwr: got %0d expected 2", wr_addr_q.size()); end
    else begin
      total++; if (wr_addr_q[0] !== 20'h00200 || wr_data_q[0] !== 8'h11) begin
        bad++; $display("[TB] FAIL cmp_wr0: got %h:%h expected 00200:11", wr_addr_q[0], wr_data_q[0]);
      end
      total++; if (wr_addr_q[1] !== 20'h00202 || wr_data_q[1] !== 8'h33) begin
        bad++; $display("[TB] FAIL cmp_wr1: got %h:%h expected 00202:33", wr_addr_q[1], wr_data_q[1]);
      end
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge CLK);
    test_reset();
    @(negedge CLK);
    RESETL = 1'b1;
    test_reset();
    test_copy();
    test_pattern_xor();
    test_wait_states();
    test_wrap();
    test_count_zero();
    test_reset_mid_write();
`ifdef BLIT_CMP_INHIBIT_EN
    test_cmp_inhibit();
`endif
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
